// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add / restoring-subtract
// datapath, fixed N+2 edge latency from acceptance to out_valid for every op.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [2:0]   dbg_state
);

    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Handshakes: in_valid&in_ready transfers an op on the edge; out_valid&out_ready retires it.
    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic           sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [N-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   result_q, result_d;
    logic           out_valid_q;

    logic [N:0]     sum, shifted, trial;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quot, rem;
    logic           is_div, div_zero, div_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        is_div   = op_q[2];
        sum      = '0;
        shifted  = '0;
        trial    = '0;
        prod     = '0;
        quot     = '0;
        rem      = '0;
        div_zero = (b_q == '0);
        div_ovf  = (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1) && !op_q[0];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                // a is signed for everything but MULHU/DIVU/REMU; b only for MULH/DIV/REM
                sign_a_d = a_q[N-1] && (op_q != 3'b011) && (op_q != 3'b101) && (op_q != 3'b111);
                sign_b_d = b_q[N-1] && ((op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110));
                mag_a_d  = sign_a_d ? -a_q : a_q;
                mag_b_d  = sign_b_d ? -b_q : b_q;
                acc_d    = is_div ? {{N{1'b0}}, mag_a_d} : '0;
                cnt_d    = CW'(N - 1);
                state_d  = S_ITER;
            end
            S_ITER: begin
                if (!is_div) begin
                    sum     = {1'b0, acc_q[2*N-1:N]} + (mag_b_q[0] ? {1'b0, mag_a_q} : '0);
                    acc_d   = {sum, acc_q[N-1:1]};
                    mag_b_d = mag_b_q >> 1;
                end else begin
                    // {rem,quot} shifted left; rem keeps its carried-out bit for the trial
                    shifted = acc_q[2*N-1:N-1];
                    trial   = shifted - {1'b0, mag_b_q};
                    if (!trial[N]) acc_d = {trial[N-1:0], acc_q[N-2:0], 1'b1};
                    else           acc_d = {shifted[N-1:0], acc_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
                quot = (sign_a_q ^ sign_b_q) ? -acc_q[N-1:0] : acc_q[N-1:0];
                rem  = sign_a_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
                case (op_q)
                    3'b000:                 result_d = prod[N-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod[2*N-1:N];
                    3'b100, 3'b101:         result_d = quot;
                    default:                result_d = rem;
                endcase
                if (is_div && div_zero)     result_d = op_q[1] ? a_q : '1;
                else if (is_div && div_ovf) result_d = op_q[1] ? '0 : {1'b1, {(N-1){1'b0}}};
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic M-extension model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M semantics via 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin up = 64'(ux) * 64'(uy); return up[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; p = ux / uy; return p[31:0]; end
            3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
        endcase
    endfunction

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: issue one op, scramble inputs during ITER, check latency/result/back-pressure
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int stall);
        int edges;
        logic [31:0] held;
        edges = 0;
        @(negedge clk);
        while (!in_ready && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom_range(0, 7));
        a        = $urandom;
        b        = $urandom;
        edges    = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 12) begin
                a = $urandom;
                b = $urandom;
            end
        end
        check({tag, "_latency"}, 32'(edges), 32'd34);
        check({tag, "_result"}, result, exp);
        held = result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_stall_result"}, result, held);
            check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_after_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_after_valid"}, 32'(out_valid), 32'd0);
    endtask

    logic [2:0]  d_op  [12];
    logic [31:0] d_a   [12];
    logic [31:0] d_b   [12];
    logic [31:0] d_exp [12];

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        d_op[0]  = 3'd0; d_a[0]  = 32'd7;        d_b[0]  = 32'hFFFFFFFD; d_exp[0]  = 32'hFFFFFFEB;
        d_op[1]  = 3'd1; d_a[1]  = 32'h80000000; d_b[1]  = 32'h80000000; d_exp[1]  = 32'h40000000;
        d_op[2]  = 3'd3; d_a[2]  = 32'hFFFFFFFF; d_b[2]  = 32'hFFFFFFFF; d_exp[2]  = 32'hFFFFFFFE;
        d_op[3]  = 3'd2; d_a[3]  = 32'hFFFFFFFF; d_b[3]  = 32'hFFFFFFFF; d_exp[3]  = 32'hFFFFFFFF;
        d_op[4]  = 3'd4; d_a[4]  = 32'hFFFFFFF9; d_b[4]  = 32'd2;        d_exp[4]  = 32'hFFFFFFFD;
        d_op[5]  = 3'd6; d_a[5]  = 32'hFFFFFFF9; d_b[5]  = 32'd2;        d_exp[5]  = 32'hFFFFFFFF;
        d_op[6]  = 3'd5; d_a[6]  = 32'd100;      d_b[6]  = 32'd7;        d_exp[6]  = 32'd14;
        d_op[7]  = 3'd7; d_a[7]  = 32'd100;      d_b[7]  = 32'd7;        d_exp[7]  = 32'd2;
        d_op[8]  = 3'd5; d_a[8]  = 32'd5;        d_b[8]  = 32'd0;        d_exp[8]  = 32'hFFFFFFFF;
        d_op[9]  = 3'd7; d_a[9]  = 32'd5;        d_b[9]  = 32'd0;        d_exp[9]  = 32'd5;
        d_op[10] = 3'd4; d_a[10] = 32'h80000000; d_b[10] = 32'hFFFFFFFF; d_exp[10] = 32'h80000000;
        d_op[11] = 3'd6; d_a[11] = 32'h80000000; d_b[11] = 32'hFFFFFFFF; d_exp[11] = 32'd0;

        // Reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, the first with a 5-cycle back-pressure hold
        for (int i = 0; i < 12; i++)
            do_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], d_exp[i], (i == 0) ? 5 : 0);

        // Asynchronous reset during ITER
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd0;
        a        = 32'd5;
        b        = 32'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_reset_mul", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        // Random ops against the reference model
        for (int i = 0; i < 200; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = pick_operand();
            r_b  = pick_operand();
            do_op($sformatf("rnd%0d_op%0d_%h_%h", i, r_op, r_a, r_b), r_op, r_a, r_b,
                  ref_model(r_op, r_a, r_b), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
